// File: rtl/bus_slave_interface_if.sv
// Bus-side signals of the four-phase command/reply handshake between one master
// and a bus slave endpoint.
interface bus_slave_interface_if;
    logic        bus_handshake_1;
    logic        bus_handshake_2;
    logic [31:0] bus_data_in;
    logic [31:0] bus_data_out;
    logic        bus_data_oe;

    modport master (
        output bus_handshake_1,
        output bus_data_in,
        input  bus_handshake_2,
        input  bus_data_out,
        input  bus_data_oe
    );

    modport slave (
        input  bus_handshake_1,
        input  bus_data_in,
        output bus_handshake_2,
        output bus_data_out,
        output bus_data_oe
    );
endinterface

// File: rtl/bus_slave_interface.sv
// Slave endpoint: takes one command word, and when addressed acknowledges it and
// returns REPLY_WORDS reply words; otherwise silently shadows the other slave's reads.
module bus_slave_interface #(
    parameter logic [3:0] SLAVE_ADDRESS = 4'h1,
    parameter int         REPLY_WORDS   = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    bus_slave_interface_if.slave  bus,
    output logic [31:0]           cmd_word,
    output logic                  cmd_valid,
    output logic [3:0]            reply_index,
    input  logic [31:0]           reply_data,
    output logic                  busy
);

    localparam logic [3:0] LP_LAST = 4'(REPLY_WORDS);

    typedef enum logic [3:0] {
        S_IDLE,
        S_DECODE,
        S_WACK,
        S_WREL,
        S_RWAIT,
        S_RLOAD,
        S_RACK,
        S_RREL,
        S_SHADOW_W,
        S_SHADOW_H,
        S_SHADOW_L
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        r_match;
    logic [31:0] r_cmd_word;
    logic [31:0] r_data_out;
    logic [3:0]  r_reply_index;
    logic [3:0]  r_shadow_cnt;

    logic        w_h1;
    logic        w_h2;
    logic        w_oe;
    logic        w_cmd_valid;
    logic        w_capture;
    logic        w_load;
    logic        w_clr_idx;
    logic        w_inc_idx;
    logic        w_clr_shadow;
    logic        w_inc_shadow;
    logic [3:0]  w_idx_next;
    logic [3:0]  w_shadow_next;

    assign w_h1          = bus.bus_handshake_1;
    assign w_idx_next    = r_reply_index + 4'd1;
    assign w_shadow_next = r_shadow_cnt + 4'd1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        w_h2         = 1'b0;
        w_oe         = 1'b0;
        w_cmd_valid  = 1'b0;
        w_capture    = 1'b0;
        w_load       = 1'b0;
        w_clr_idx    = 1'b0;
        w_inc_idx    = 1'b0;
        w_clr_shadow = 1'b0;
        w_inc_shadow = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_h1) begin
                    w_capture = 1'b1;
                    w_next    = S_DECODE;
                end
            end
            S_DECODE: begin
                w_cmd_valid = r_match;
                w_next      = r_match ? S_WACK : S_SHADOW_W;
            end
            S_WACK: begin
                w_h2 = 1'b1;
                if (!w_h1) w_next = S_WREL;
            end
            S_WREL: begin
                w_clr_idx = 1'b1;
                w_next    = S_RWAIT;
            end
            // Reply word is latched on the request edge so it is already on the bus
            // a full cycle before the acknowledge rises.
            S_RWAIT: begin
                if (w_h1) begin
                    w_load = 1'b1;
                    w_next = S_RLOAD;
                end
            end
            S_RLOAD: begin
                w_oe   = 1'b1;
                w_next = S_RACK;
            end
            S_RACK: begin
                w_h2 = 1'b1;
                w_oe = 1'b1;
                if (!w_h1) w_next = S_RREL;
            end
            S_RREL: begin
                w_inc_idx = 1'b1;
                w_next    = (w_idx_next == LP_LAST) ? S_IDLE : S_RWAIT;
            end
            // Foreign transaction: follow its handshakes without driving anything.
            S_SHADOW_W: begin
                if (!w_h1) begin
                    w_clr_shadow = 1'b1;
                    w_next       = S_SHADOW_H;
                end
            end
            S_SHADOW_H: begin
                if (w_h1) w_next = S_SHADOW_L;
            end
            S_SHADOW_L: begin
                if (!w_h1) begin
                    w_inc_shadow = 1'b1;
                    w_next       = (w_shadow_next == LP_LAST) ? S_IDLE : S_SHADOW_H;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_match       <= 1'b0;
            r_cmd_word    <= 32'd0;
            r_data_out    <= 32'd0;
            r_reply_index <= 4'd0;
            r_shadow_cnt  <= 4'd0;
        end else begin
            if (w_capture) begin
                r_cmd_word <= bus.bus_data_in;
                r_match    <= (bus.bus_data_in[31:28] == SLAVE_ADDRESS);
            end
            if (w_load) r_data_out <= reply_data;
            if (w_clr_idx) begin
                r_reply_index <= 4'd0;
            end else if (w_inc_idx) begin
                r_reply_index <= w_idx_next;
            end
            if (w_clr_shadow) begin
                r_shadow_cnt <= 4'd0;
            end else if (w_inc_shadow) begin
                r_shadow_cnt <= w_shadow_next;
            end
        end
    end

    assign bus.bus_handshake_2 = w_h2;
    assign bus.bus_data_oe     = w_oe;
    assign bus.bus_data_out    = r_data_out;
    assign cmd_word            = r_cmd_word;
    assign cmd_valid           = w_cmd_valid;
    assign reply_index         = r_reply_index;
    assign busy                = (r_state != S_IDLE);

endmodule

// File: tb/tb_bus_slave_interface.sv
// Directed bench: three endpoints (REPLY_WORDS 2, 1, 15) driven by a four-phase
// master model with latency, data and quiet-bus expectations computed by hand.
module tb_bus_slave_interface;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [2:0]  h1;
    logic [31:0] din [3];
    logic        ovr;

    logic [31:0] w_cw   [3];
    logic [31:0] w_dout [3];
    logic [31:0] w_rd   [3];
    logic [3:0]  w_ri   [3];
    logic [2:0]  w_h2;
    logic [2:0]  w_oe;
    logic [2:0]  w_cv;
    logic [2:0]  w_busy;

    int checks = 0;
    int errors = 0;

    bus_slave_interface_if bif0 ();
    bus_slave_interface_if bif1 ();
    bus_slave_interface_if bif2 ();

    assign bif0.bus_handshake_1 = h1[0];
    assign bif1.bus_handshake_1 = h1[1];
    assign bif2.bus_handshake_1 = h1[2];
    assign bif0.bus_data_in     = din[0];
    assign bif1.bus_data_in     = din[1];
    assign bif2.bus_data_in     = din[2];
    assign w_h2[0]   = bif0.bus_handshake_2;
    assign w_h2[1]   = bif1.bus_handshake_2;
    assign w_h2[2]   = bif2.bus_handshake_2;
    assign w_oe[0]   = bif0.bus_data_oe;
    assign w_oe[1]   = bif1.bus_data_oe;
    assign w_oe[2]   = bif2.bus_data_oe;
    assign w_dout[0] = bif0.bus_data_out;
    assign w_dout[1] = bif1.bus_data_out;
    assign w_dout[2] = bif2.bus_data_out;

    // Local logic model: reply word = CAFE_0000 + index, with an override on slave 0.
    assign w_rd[0] = ovr ? 32'hDEAD_BEEF : (32'hCAFE_0000 + {28'd0, w_ri[0]});
    assign w_rd[1] = 32'hCAFE_0000 + {28'd0, w_ri[1]};
    assign w_rd[2] = 32'hCAFE_0000 + {28'd0, w_ri[2]};

    bus_slave_interface #(.SLAVE_ADDRESS(4'h1), .REPLY_WORDS(2)) dut0 (
        .clk(clk), .reset(reset), .bus(bif0), .cmd_word(w_cw[0]), .cmd_valid(w_cv[0]),
        .reply_index(w_ri[0]), .reply_data(w_rd[0]), .busy(w_busy[0]));
    bus_slave_interface #(.SLAVE_ADDRESS(4'h1), .REPLY_WORDS(1)) dut1 (
        .clk(clk), .reset(reset), .bus(bif1), .cmd_word(w_cw[1]), .cmd_valid(w_cv[1]),
        .reply_index(w_ri[1]), .reply_data(w_rd[1]), .busy(w_busy[1]));
    bus_slave_interface #(.SLAVE_ADDRESS(4'h1), .REPLY_WORDS(15)) dut2 (
        .clk(clk), .reset(reset), .bus(bif2), .cmd_word(w_cw[2]), .cmd_valid(w_cv[2]),
        .reply_index(w_ri[2]), .reply_data(w_rd[2]), .busy(w_busy[2]));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One four-phase word. ack=1: addressed, latency and data checked; ack=0: bus must stay quiet.
    task automatic hs(input int s, input bit wr, input logic [31:0] wdata, input bit ack,
                      input logic [31:0] exp_rd, input logic [3:0] exp_idx);
        int n;
        if (wr) din[s] = wdata;
        h1[s] = 1'b1;
        if (ack) begin
            tick();
            checks++;
            if (w_h2[s] !== 1'b0) begin
                errors++;
                $display("FAIL h2_early s=%0d got=%b exp=0", s, w_h2[s]);
            end
            if (wr) begin
                checks++;
                if (w_cv[s] !== 1'b1 || w_cw[s] !== wdata) begin
                    errors++;
                    $display("FAIL cmd_valid s=%0d got=%b/%h exp=1/%h", s, w_cv[s], w_cw[s], wdata);
                end
            end else begin
                checks++;
                if (w_oe[s] !== 1'b1 || w_dout[s] !== exp_rd || w_ri[s] !== exp_idx) begin
                    errors++;
                    $display("FAIL rd_load s=%0d got oe=%b data=%h idx=%0d exp oe=1 data=%h idx=%0d",
                             s, w_oe[s], w_dout[s], w_ri[s], exp_rd, exp_idx);
                end
            end
            n = 1;
            while (w_h2[s] !== 1'b1 && n < 10) begin
                tick();
                n++;
            end
            checks++;
            if (n != 2) begin
                errors++;
                $display("FAIL h2_latency s=%0d got=%0d exp=2", s, n);
            end
            if (wr) begin
                checks++;
                if (w_cv[s] !== 1'b0) begin
                    errors++;
                    $display("FAIL cmd_valid_pulse s=%0d got=%b exp=0", s, w_cv[s]);
                end
            end else begin
                checks++;
                if (w_oe[s] !== 1'b1 || w_dout[s] !== exp_rd) begin
                    errors++;
                    $display("FAIL rd_hold s=%0d got oe=%b data=%h exp oe=1 data=%h",
                             s, w_oe[s], w_dout[s], exp_rd);
                end
            end
            h1[s] = 1'b0;
            tick();
            checks++;
            if (w_h2[s] !== 1'b0 || w_oe[s] !== 1'b0) begin
                errors++;
                $display("FAIL release s=%0d got h2=%b oe=%b exp 0/0", s, w_h2[s], w_oe[s]);
            end
            tick();
        end else begin
            for (int i = 0; i < 4; i++) begin
                tick();
                checks++;
                if ({w_h2[s], w_oe[s], w_cv[s]} !== 3'b000) begin
                    errors++;
                    $display("FAIL shadow_quiet s=%0d got h2/oe/cv=%b%b%b exp 000",
                             s, w_h2[s], w_oe[s], w_cv[s]);
                end
            end
            h1[s] = 1'b0;
            tick();
            checks++;
            if ({w_h2[s], w_oe[s], w_cv[s]} !== 3'b000) begin
                errors++;
                $display("FAIL shadow_release s=%0d got h2/oe/cv=%b%b%b exp 000",
                         s, w_h2[s], w_oe[s], w_cv[s]);
            end
            tick();
        end
    endtask

    task automatic run_txn(input int s, input logic [31:0] cmd, input int nwords);
        hs(s, 1'b1, cmd, 1'b1, 32'd0, 4'd0);
        for (int i = 0; i < nwords; i++) begin
            hs(s, 1'b0, 32'd0, 1'b1, 32'hCAFE_0000 + 32'(i), 4'(i));
        end
        checks++;
        if (w_busy[s] !== 1'b0) begin
            errors++;
            $display("FAIL txn_end_busy s=%0d got=%b exp=0", s, w_busy[s]);
        end
    endtask

    task automatic test_reset();
        h1    = 3'b000;
        ovr   = 1'b0;
        din[0] = 32'd0;
        din[1] = 32'd0;
        din[2] = 32'd0;
        reset = 1'b1;
        #2 reset = 1'b0;
        tick();
        tick();
        for (int s = 0; s < 3; s++) begin
            checks++;
            if ({w_h2[s], w_oe[s], w_cv[s], w_busy[s]} !== 4'b0000 || w_dout[s] !== 32'd0 ||
                w_cw[s] !== 32'd0 || w_ri[s] !== 4'd0) begin
                errors++;
                $display("FAIL reset_state s=%0d got h2/oe/cv/busy=%b%b%b%b dout=%h cw=%h idx=%0d exp all 0",
                         s, w_h2[s], w_oe[s], w_cv[s], w_busy[s], w_dout[s], w_cw[s], w_ri[s]);
            end
        end
        reset = 1'b1;
        tick();
        checks++;
        if (w_busy !== 3'b000) begin
            errors++;
            $display("FAIL reset_release_busy got=%b exp=000", w_busy);
        end
    endtask

    task automatic test_addressed();
        run_txn(0, 32'h1A00_0055, 2);
    endtask

    task automatic test_unaddressed();
        hs(0, 1'b1, 32'h2000_0000, 1'b0, 32'd0, 4'd0);
        hs(0, 1'b0, 32'd0, 1'b0, 32'd0, 4'd0);
        hs(0, 1'b0, 32'd0, 1'b0, 32'd0, 4'd0);
        checks++;
        if (w_busy[0] !== 1'b0 || w_cw[0] !== 32'h2000_0000) begin
            errors++;
            $display("FAIL unaddr_end got busy=%b cw=%h exp busy=0 cw=20000000", w_busy[0], w_cw[0]);
        end
        run_txn(0, 32'h1000_00AA, 2);
    endtask

    task automatic test_reply_hold();
        hs(0, 1'b1, 32'h1C00_0003, 1'b1, 32'd0, 4'd0);
        h1[0] = 1'b1;
        tick();
        tick();
        ovr = 1'b1;
        tick();
        checks++;
        if (w_h2[0] !== 1'b1 || w_dout[0] !== 32'hCAFE_0000) begin
            errors++;
            $display("FAIL reply_hold got h2=%b data=%h exp h2=1 data=cafe0000", w_h2[0], w_dout[0]);
        end
        h1[0] = 1'b0;
        tick();
        checks++;
        if (w_dout[0] !== 32'hCAFE_0000 || w_oe[0] !== 1'b0) begin
            errors++;
            $display("FAIL reply_hold_rel got oe=%b data=%h exp oe=0 data=cafe0000", w_oe[0], w_dout[0]);
        end
        ovr = 1'b0;
        tick();
        hs(0, 1'b0, 32'd0, 1'b1, 32'hCAFE_0001, 4'd1);
        checks++;
        if (w_busy[0] !== 1'b0) begin
            errors++;
            $display("FAIL reply_hold_busy got=%b exp=0", w_busy[0]);
        end
    endtask

    task automatic test_reset_mid_read();
        hs(0, 1'b1, 32'h1D00_0004, 1'b1, 32'd0, 4'd0);
        h1[0] = 1'b1;
        tick();
        tick();
        checks++;
        if (w_h2[0] !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_rack got h2=%b exp=1", w_h2[0]);
        end
        #1 reset = 1'b0;
        #1;
        checks++;
        if (w_h2[0] !== 1'b0 || w_oe[0] !== 1'b0 || w_busy[0] !== 1'b0 ||
            w_dout[0] !== 32'd0 || w_ri[0] !== 4'd0) begin
            errors++;
            $display("FAIL async_reset got h2=%b oe=%b busy=%b dout=%h idx=%0d exp 0",
                     w_h2[0], w_oe[0], w_busy[0], w_dout[0], w_ri[0]);
        end
        h1[0] = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        run_txn(0, 32'h1B00_0001, 2);
    endtask

    task automatic test_back_to_back();
        run_txn(1, 32'h1000_0001, 1);
        run_txn(1, 32'h1000_0002, 1);
        run_txn(2, 32'h1F00_000F, 15);
        run_txn(2, 32'h1F00_0010, 15);
    endtask

    initial begin
        test_reset();
        test_addressed();
        test_unaddressed();
        test_reply_hold();
        test_reset_mid_read();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
